// File: rtl/countdown_pkg.sv
// countdown_pkg: shared FSM encoding and BCD constants for the seconds countdown
package countdown_pkg;
  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, EXPIRED} state_t;
  localparam int DIGIT_W = 4;
  localparam int MAX_SECS = 99;
endpackage

// File: rtl/bcd_digit_down.sv
// bcd_digit_down: single BCD digit decrementer, borrows when wrapping 0 to 9
module bcd_digit_down
  import countdown_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               dec_en,
  output logic [DIGIT_W-1:0] next_digit,
  output logic               borrow
);
  always_comb begin
    borrow = dec_en && (digit == '0);
    next_digit = !dec_en ? digit : (digit == '0) ? DIGIT_W'(9) : digit - 1'b1;
  end
endmodule

// File: rtl/seconds_countdown.sv
// seconds_countdown: two-digit BCD seconds countdown with run/pause/expire control
module seconds_countdown
  import countdown_pkg::*;
#(
  parameter int START_SECONDS = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               load,
  input  logic [6:0]         load_secs,
  input  logic               start,
  input  logic               pause,
  output logic [DIGIT_W-1:0] secs_tens,
  output logic [DIGIT_W-1:0] secs_ones,
  output logic               running,
  output logic               expired,
  output logic               expired_pulse
);
  localparam logic [DIGIT_W-1:0] RST_TENS = DIGIT_W'(START_SECONDS / 10);
  localparam logic [DIGIT_W-1:0] RST_ONES = DIGIT_W'(START_SECONDS % 10);
  state_t state, state_n;
  logic [DIGIT_W-1:0] tens, ones, tens_n, ones_n, ld_tens, ld_ones, dec_tens, dec_ones;
  logic [6:0] clamped;
  logic pulse, pulse_n, do_tick, ones_borrow, unused_tens_borrow, count_zero, at_one;
  always_comb begin
    clamped = (load_secs > 7'(MAX_SECS)) ? 7'(MAX_SECS) : load_secs;
    ld_tens = DIGIT_W'(clamped / 7'd10);
    ld_ones = DIGIT_W'(clamped % 7'd10);
    count_zero = (tens == '0) && (ones == '0);
    at_one = (tens == '0) && (ones == DIGIT_W'(1));
    // pause wins over a coincident tick, so the tick is simply not applied
    do_tick = (state == RUNNING) && tick && !pause;
  end
  bcd_digit_down u_ones (
    .digit(ones), .dec_en(do_tick), .next_digit(dec_ones), .borrow(ones_borrow)
  );
  bcd_digit_down u_tens (
    .digit(tens), .dec_en(do_tick && ones_borrow), .next_digit(dec_tens), .borrow(unused_tens_borrow)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tens  <= RST_TENS;
      ones  <= RST_ONES;
      pulse <= 1'b0;
    end else begin
      state <= state_n;
      tens  <= tens_n;
      ones  <= ones_n;
      pulse <= pulse_n;
    end
  end
  always_comb begin
    state_n = state;
    tens_n = load ? ld_tens : dec_tens;
    ones_n = load ? ld_ones : dec_ones;
    pulse_n = 1'b0;
    if (load) state_n = IDLE;
    else
      case (state)
        IDLE:    if (start && !count_zero) state_n = RUNNING;
        RUNNING: if (pause) state_n = PAUSED;
                 else if (tick && at_one) begin
                   state_n = EXPIRED;
                   pulse_n = 1'b1;
                 end
        PAUSED:  if (start) state_n = RUNNING;
        default: state_n = state;
      endcase
  end
  always_comb begin
    secs_tens = tens;
    secs_ones = ones;
    running = (state == RUNNING);
    expired = (state == EXPIRED);
    expired_pulse = pulse;
  end
endmodule

// File: tb/tb_seconds_countdown.sv
// tb_seconds_countdown: directed and randomized checks against a behavioural countdown model
module tb_seconds_countdown;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [6:0] load_secs = '0;
  logic [3:0] secs_tens, secs_ones;
  logic running, expired, expired_pulse;
  int vectors = 0, errors = 0;
  int m_cnt = 60, m_st = 0;
  bit m_pulse = 0;

  always #5 clk = ~clk;

  seconds_countdown #(.START_SECONDS(60)) dut (
    .clk(clk), .rst(rst), .tick(tick), .load(load), .load_secs(load_secs),
    .start(start), .pause(pause), .secs_tens(secs_tens), .secs_ones(secs_ones),
    .running(running), .expired(expired), .expired_pulse(expired_pulse)
  );

  // model states: 0 idle, 1 running, 2 paused, 3 expired; count kept as a plain integer
  task automatic cycle(input bit r, input bit t, input bit l, input int ls, input bit s, input bit p);
    rst = r; tick = t; load = l; load_secs = 7'(ls); start = s; pause = p;
    @(posedge clk);
    m_pulse = 0;
    if (r) begin m_cnt = 60; m_st = 0; end
    else if (l) begin m_cnt = (ls > 99) ? 99 : ls; m_st = 0; end
    else if (m_st == 0 && s && m_cnt != 0) m_st = 1;
    else if (m_st == 2 && s) m_st = 1;
    else if (m_st == 1 && p) m_st = 2;
    else if (m_st == 1 && t) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin m_st = 3; m_pulse = 1; end
    end
    #1;
    rst = 0; tick = 0; load = 0; start = 0; pause = 0;
  endtask

  task automatic test_reset;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 33, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    vectors++;
    if (secs_tens !== 4'd6 || secs_ones !== 4'd0 || running !== 1'b0 || expired !== 1'b0 || expired_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset: got %0d%0d run=%b exp=%b pulse=%b, want 60 0 0 0", secs_tens, secs_ones, running, expired, expired_pulse);
    end
    cycle(0, 0, 0, 0, 1, 0);
    vectors++;
    if (running !== 1'b1) begin errors++; $display("FAIL reset_idle_start: running=%b want 1", running); end
  endtask

  task automatic test_expiry;
    cycle(0, 0, 1, 3, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    for (int i = 2; i >= 0; i--) begin
      cycle(0, 1, 0, 0, 0, 0);
      vectors++;
      if (secs_tens !== 4'd0 || secs_ones !== 4'(i) || expired_pulse !== (i == 0)) begin
        errors++;
        $display("FAIL expiry_step%0d: got %0d%0d pulse=%b, want 0%0d pulse=%b", i, secs_tens, secs_ones, expired_pulse, i, i == 0);
      end
    end
    vectors++;
    if (expired !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL expiry_state: exp=%b run=%b want 1 0", expired, running); end
    cycle(0, 1, 0, 0, 0, 0);
    vectors++;
    if (expired_pulse !== 1'b0 || expired !== 1'b1 || secs_tens !== 4'd0 || secs_ones !== 4'd0) begin
      errors++;
      $display("FAIL expiry_hold: got %0d%0d pulse=%b exp=%b, want 00 0 1", secs_tens, secs_ones, expired_pulse, expired);
    end
  endtask

  task automatic test_borrow_clamp;
    cycle(0, 0, 1, 10, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 0, 0);
    vectors++;
    if (secs_tens !== 4'd0 || secs_ones !== 4'd9) begin errors++; $display("FAIL borrow: got %0d%0d want 09", secs_tens, secs_ones); end
    cycle(0, 0, 1, 120, 0, 0);
    vectors++;
    if (secs_tens !== 4'd9 || secs_ones !== 4'd9 || running !== 1'b0) begin
      errors++;
      $display("FAIL clamp: got %0d%0d run=%b want 99 0", secs_tens, secs_ones, running);
    end
  endtask

  task automatic test_pause;
    cycle(0, 0, 1, 45, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 0, 1);
    vectors++;
    if (secs_tens !== 4'd4 || secs_ones !== 4'd5 || running !== 1'b0 || expired !== 1'b0) begin
      errors++;
      $display("FAIL pause_tick: got %0d%0d run=%b want 45 0", secs_tens, secs_ones, running);
    end
    cycle(0, 1, 0, 0, 0, 0);
    vectors++;
    if (secs_tens !== 4'd4 || secs_ones !== 4'd5) begin errors++; $display("FAIL paused_tick: got %0d%0d want 45", secs_tens, secs_ones); end
    cycle(0, 0, 0, 0, 1, 1);
    vectors++;
    if (running !== 1'b1) begin errors++; $display("FAIL resume: running=%b want 1", running); end
    cycle(0, 1, 0, 0, 0, 0);
    vectors++;
    if (secs_tens !== 4'd4 || secs_ones !== 4'd4) begin errors++; $display("FAIL resume_tick: got %0d%0d want 44", secs_tens, secs_ones); end
  endtask

  task automatic test_load_priority;
    cycle(0, 0, 1, 7, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 1, 20, 1, 0);
    vectors++;
    if (secs_tens !== 4'd2 || secs_ones !== 4'd0 || running !== 1'b0) begin
      errors++;
      $display("FAIL load_prio: got %0d%0d run=%b want 20 0", secs_tens, secs_ones, running);
    end
  endtask

  task automatic test_start_ignore;
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    vectors++;
    if (running !== 1'b0 || secs_tens !== 4'd0 || secs_ones !== 4'd0) begin
      errors++;
      $display("FAIL start_zero: got %0d%0d run=%b want 00 0", secs_tens, secs_ones, running);
    end
    cycle(0, 0, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 1);
    vectors++;
    if (expired !== 1'b1 || running !== 1'b0 || expired_pulse !== 1'b0) begin
      errors++;
      $display("FAIL start_expired: exp=%b run=%b pulse=%b want 1 0 0", expired, running, expired_pulse);
    end
    cycle(0, 0, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(1, 1, 0, 0, 0, 0);
    vectors++;
    if (expired_pulse !== 1'b0 || expired !== 1'b0 || secs_tens !== 4'd6 || secs_ones !== 4'd0) begin
      errors++;
      $display("FAIL rst_prio: got %0d%0d exp=%b pulse=%b want 60 0 0", secs_tens, secs_ones, expired, expired_pulse);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 1500; n++) begin
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, 24) == 0,
            int'($urandom_range(0, 127)), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      vectors++;
      if (secs_tens !== 4'(m_cnt / 10) || secs_ones !== 4'(m_cnt % 10) || running !== (m_st == 1) ||
          expired !== (m_st == 3) || expired_pulse !== m_pulse) begin
        errors++;
        $display("FAIL random[%0d]: got %0d%0d run=%b exp=%b pulse=%b, want %0d run=%b exp=%b pulse=%b",
                 n, secs_tens, secs_ones, running, expired, expired_pulse, m_cnt, m_st == 1, m_st == 3, m_pulse);
      end
    end
  endtask

  initial begin
    test_reset;
    test_expiry;
    test_borrow_clamp;
    test_pause;
    test_load_priority;
    test_start_ignore;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
